alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Parametrised EX-stage ALU: decodes aluOp/funct internally, executes, and returns a registered result
//  behind valid/ready handshakes. Adds logic, shift, set-less-than and overflow detection.
//  Adds an iterative MULT/MULTU with HI/LO registers and MFHI/MFLO reads.
//  Sits between ID/EX operand latch and EX/MEM register; stalls the pipe via in_ready.
// PARAMETERS
//  WIDTH   32  datapath width; power of 2, >=8; SW = log2(WIDTH) = shift-amount width
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      request valid
//  in_ready   out  1      unit can accept request this cycle
//  alu_op     in   3      000 add, 001 sub, 010 R-type(funct), 011 and, 100 or, 101 slt, 110 sltu, 111 lui
//  funct      in   6      R-type function field (used only when alu_op=010)
//  shamt      in   SW     immediate shift amount
//  op_a       in   WIDTH  rs operand
//  op_b       in   WIDTH  rt / immediate operand
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  result     out  WIDTH  registered result
//  zero       out  1      result == 0
//  ovf        out  1      signed overflow (add/sub with funct 100000/100010, alu_op 000/001)
//  illegal    out  1      unsupported funct; result forced 0
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE; out_valid, result, zero, ovf, illegal, HI, LO = 0. In-flight multiply aborted.
//  Accept on clk edge with in_valid & in_ready. in_ready = (state==IDLE) & (~out_valid | out_ready).
//  Output register holds result/flags stable while out_valid & ~out_ready; out_valid drops after out_ready unless new accept.
//  Single-cycle ops: accepted at edge N -> out_valid=1 after edge N; throughput 1/cycle under out_ready=1.
//  funct: 100000 add(ovf) 100001 addu 100010 sub(ovf) 100011 subu 100100 and 100101 or 100110 xor
//   100111 nor 101010 slt 101011 sltu 000000 sll 000010 srl 000011 sra 000100 sllv 000110 srlv
//   000111 srav 011000 mult 011001 multu 010000 mfhi 010010 mflo; any other -> illegal=1, result=0.
//  Shifts: value = op_b; amount = shamt (fixed) or op_a[SW-1:0] (variable); sra sign-fills.
//  slt/sltu: result = {WIDTH-1 zeros, cmp}. lui (alu_op 111): result = op_b << (WIDTH/2).
//  Arithmetic mod 2^WIDTH; ovf only for signed add/sub; result still wraps when ovf=1; HI/LO untouched.
//  FSM: IDLE -> MUL on accepted mult/multu; MUL runs exactly WIDTH cycles (shift-add on |op| magnitudes
//   for mult, raw for multu); last MUL edge writes {HI,LO} = 2*WIDTH product (negated if signs differ,
//   mult only), result=LO, out_valid=1, state -> IDLE. in_ready=0 throughout MUL.
//  Mult latency = WIDTH cycles accept-to-out_valid; ovf=0, zero reflects LO.
//  mfhi/mflo single-cycle; read HI/LO as of accept edge (always post-multiply, since MUL blocks accept).
//  illegal/ovf/zero registered with result, valid only while out_valid=1.
//  Reset mid-MUL: return to IDLE, HI/LO=0, no out_valid pulse; in_ready=1 first cycle after rst_n rises.
// TESTING (WIDTH=32)
//  alu_op=010 funct=100000 a=7FFFFFFF b=1 -> result 80000000 ovf=1; funct 100001 same -> ovf=0 zero=0
//  sra b=80000000 shamt=4 -> F8000000; srlv a=0x24 b=80000000 -> 08000000; sub a=b=5 -> zero=1
//  mult a=FFFFFFFD(-3) b=5 -> in_ready=0 32 cycles, out_valid at cycle 32, LO=FFFFFFF1; mfhi -> FFFFFFFF
//  multu a=FFFFFFFF b=2 -> HI=00000001 LO=FFFFFFFE; next mflo -> FFFFFFFE
//  out_ready=0 3 cycles with in_valid=1 -> result stable, in_ready=0, no accept; out_ready=1 -> 1 result/cycle
//  funct=111111 -> illegal=1 result=0 HI/LO unchanged; rst_n=0 at MUL cycle 10 -> out_valid=0, HI=LO=0

Source files
------------

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: EX-stage ALU with valid/ready handshakes on both sides.
// Single-cycle ops cover add/sub (with signed overflow), logic ops, shifts,
// set-less-than and lui. MULT/MULTU run an iterative shift-add over WIDTH
// cycles into HI/LO. MFHI/MFLO read those registers back.
//
// Ports:
//   clk, rst_n           clock and asynchronous active-low reset
//   in_valid / in_ready  request handshake (in_ready low while multiplying
//                        or while an unconsumed result is held)
//   alu_op, funct, shamt operation select, R-type function, shift amount
//   op_a, op_b           rs and rt/immediate operands
//   out_valid/out_ready  result handshake
//   result, zero, ovf, illegal  registered result and flags
module alu_exec_unit #(
    parameter int WIDTH = 32,
    localparam int SW = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alu_op,
    input  logic [5:0]       funct,
    input  logic [SW-1:0]    shamt,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             ovf,
    output logic             illegal
);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t             state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q, zero_d;
    logic               ovf_q, ovf_d;
    logic               illegal_q, illegal_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [SW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH:0]   prod_q, prod_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic               neg_q, neg_d;

    logic [WIDTH-1:0]   sum, diff;
    logic               add_ovf, sub_ovf, slt_bit, sltu_bit;
    logic [WIDTH-1:0]   dec_res;
    logic               dec_ovf, dec_ill, dec_mul, dec_signed;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               accept;
    logic [WIDTH:0]     upper;
    logic [2*WIDTH:0]   prod_step;
    logic [2*WIDTH-1:0] product;

    // Operation decode and single-cycle datapath
    always_comb begin
        sum        = op_a + op_b;
        diff       = op_a - op_b;
        add_ovf    = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum[WIDTH-1] != op_a[WIDTH-1]);
        sub_ovf    = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (diff[WIDTH-1] != op_a[WIDTH-1]);
        slt_bit    = $signed(op_a) < $signed(op_b);
        sltu_bit   = op_a < op_b;
        dec_res    = '0;
        dec_ovf    = 1'b0;
        dec_ill    = 1'b0;
        dec_mul    = 1'b0;
        dec_signed = 1'b0;
        case (alu_op)
            3'b000: begin dec_res = sum;  dec_ovf = add_ovf; end
            3'b001: begin dec_res = diff; dec_ovf = sub_ovf; end
            3'b010: begin
                case (funct)
                    6'b100000: begin dec_res = sum;  dec_ovf = add_ovf; end
                    6'b100001: dec_res = sum;
                    6'b100010: begin dec_res = diff; dec_ovf = sub_ovf; end
                    6'b100011: dec_res = diff;
                    6'b100100: dec_res = op_a & op_b;
                    6'b100101: dec_res = op_a | op_b;
                    6'b100110: dec_res = op_a ^ op_b;
                    6'b100111: dec_res = ~(op_a | op_b);
                    6'b101010: dec_res[0] = slt_bit;
                    6'b101011: dec_res[0] = sltu_bit;
                    6'b000000: dec_res = op_b << shamt;
                    6'b000010: dec_res = op_b >> shamt;
                    6'b000011: dec_res = $unsigned($signed(op_b) >>> shamt);
                    6'b000100: dec_res = op_b << op_a[SW-1:0];
                    6'b000110: dec_res = op_b >> op_a[SW-1:0];
                    6'b000111: dec_res = $unsigned($signed(op_b) >>> op_a[SW-1:0]);
                    6'b011000: begin dec_mul = 1'b1; dec_signed = 1'b1; end
                    6'b011001: dec_mul = 1'b1;
                    6'b010000: dec_res = hi_q;
                    6'b010010: dec_res = lo_q;
                    default:   dec_ill = 1'b1;
                endcase
            end
            3'b011: dec_res = op_a & op_b;
            3'b100: dec_res = op_a | op_b;
            3'b101: dec_res[0] = slt_bit;
            3'b110: dec_res[0] = sltu_bit;
            3'b111: dec_res = op_b << (WIDTH / 2);
        endcase
        // Signed multiply works on magnitudes; the sign is reapplied at the end.
        a_mag = (dec_signed && op_a[WIDTH-1]) ? -op_a : op_a;
        b_mag = (dec_signed && op_b[WIDTH-1]) ? -op_b : op_b;
    end

    // Next-state, handshake and multiply sequencing
    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        zero_d      = zero_q;
        ovf_d       = ovf_q;
        illegal_d   = illegal_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        cnt_d       = cnt_q;
        prod_d      = prod_q;
        mcand_d     = mcand_q;
        neg_d       = neg_q;

        in_ready = (state_q == S_IDLE) && (!out_valid_q || out_ready);
        accept   = in_valid && in_ready;

        // prod_q holds {partial sum, remaining multiplier bits}; one bit retires per cycle.
        upper     = prod_q[2*WIDTH:WIDTH] + (prod_q[0] ? {1'b0, mcand_q} : '0);
        prod_step = {upper, prod_q[WIDTH-1:0]} >> 1;
        product   = neg_q ? -prod_step[2*WIDTH-1:0] : prod_step[2*WIDTH-1:0];

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (dec_mul) begin
                        state_d = S_MUL;
                        cnt_d   = '0;
                        mcand_d = b_mag;
                        prod_d  = '0;
                        prod_d[WIDTH-1:0] = a_mag;
                        neg_d   = dec_signed && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                    end else begin
                        out_valid_d = 1'b1;
                        result_d    = dec_res;
                        zero_d      = (dec_res == '0);
                        ovf_d       = dec_ovf;
                        illegal_d   = dec_ill;
                    end
                end
            end
            S_MUL: begin
                prod_d = prod_step;
                cnt_d  = cnt_q + SW'(1);
                if (cnt_q == SW'(WIDTH - 1)) begin
                    state_d     = S_IDLE;
                    hi_d        = product[2*WIDTH-1:WIDTH];
                    lo_d        = product[WIDTH-1:0];
                    result_d    = product[WIDTH-1:0];
                    zero_d      = (product[WIDTH-1:0] == '0);
                    ovf_d       = 1'b0;
                    illegal_d   = 1'b0;
                    out_valid_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            zero_q      <= 1'b0;
            ovf_q       <= 1'b0;
            illegal_q   <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            cnt_q       <= '0;
            prod_q      <= '0;
            mcand_q     <= '0;
            neg_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            zero_q      <= zero_d;
            ovf_q       <= ovf_d;
            illegal_q   <= illegal_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            cnt_q       <= cnt_d;
            prod_q      <= prod_d;
            mcand_q     <= mcand_d;
            neg_q       <= neg_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign zero      = zero_q;
    assign ovf       = ovf_q;
    assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: directed and randomized checks of alu_exec_unit (WIDTH=32)
// against an arithmetic reference model with its own HI/LO copy.
module tb_alu_exec_unit;

    localparam int W = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  alu_op = '0;
    logic [5:0]  funct = '0;
    logic [4:0]  shamt = '0;
    logic [31:0] op_a = '0;
    logic [31:0] op_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        zero, ovf, illegal;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] hi_m = '0;
    logic [31:0] lo_m = '0;
    logic [31:0] last_res;
    logic        last_zero, last_ovf, last_ill;

    logic [5:0] legal_fn [20] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                                  6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b101011,
                                  6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110,
                                  6'b000111, 6'b011000, 6'b011001, 6'b010000, 6'b010010};

    alu_exec_unit #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .funct     (funct),
        .shamt     (shamt),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .ovf       (ovf),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain 64-bit arithmetic on the operation's meaning.
    function automatic void model(input logic [2:0] op, input logic [5:0] fn, input logic [4:0] sh,
                                  input logic [31:0] a, input logic [31:0] b,
                                  input logic [31:0] hi, input logic [31:0] lo,
                                  output logic [31:0] r, output logic ov, output logic il,
                                  output logic is_mul, output logic [63:0] p);
        longint sa, sb, s;
        int     va;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        va = int'(a % 32);
        r = '0; ov = 1'b0; il = 1'b0; is_mul = 1'b0; p = '0;
        case (op)
            3'd0: begin s = sa + sb; r = s[31:0]; ov = (s != longint'(int'(s))); end
            3'd1: begin s = sa - sb; r = s[31:0]; ov = (s != longint'(int'(s))); end
            3'd2: begin
                case (fn)
                    6'b100000: begin s = sa + sb; r = s[31:0]; ov = (s != longint'(int'(s))); end
                    6'b100001: r = a + b;
                    6'b100010: begin s = sa - sb; r = s[31:0]; ov = (s != longint'(int'(s))); end
                    6'b100011: r = a - b;
                    6'b100100: r = a & b;
                    6'b100101: r = a | b;
                    6'b100110: r = a ^ b;
                    6'b100111: r = ~(a | b);
                    6'b101010: r = (sa < sb) ? 32'd1 : 32'd0;
                    6'b101011: r = (a < b) ? 32'd1 : 32'd0;
                    6'b000000: r = b << sh;
                    6'b000010: r = b >> sh;
                    6'b000011: r = 32'(int'(b) >>> sh);
                    6'b000100: r = b << va;
                    6'b000110: r = b >> va;
                    6'b000111: r = 32'(int'(b) >>> va);
                    6'b011000: begin is_mul = 1'b1; p = sa * sb; r = p[31:0]; end
                    6'b011001: begin is_mul = 1'b1; p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
                    6'b010000: r = hi;
                    6'b010010: r = lo;
                    default:   il = 1'b1;
                endcase
            end
            3'd3: r = a & b;
            3'd4: r = a | b;
            3'd5: r = (sa < sb) ? 32'd1 : 32'd0;
            3'd6: r = (a < b) ? 32'd1 : 32'd0;
            default: r = b << 16;
        endcase
    endfunction

    // Issue one request, wait for its result, compare everything.
    task automatic run_op(input string tag, input logic [2:0] op, input logic [5:0] fn,
                          input logic [4:0] sh, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] er;
        logic        eov, eil, emul;
        logic [63:0] ep;
        int          waitc;
        int          lat;
        logic        rdy_low;
        model(op, fn, sh, a, b, hi_m, lo_m, er, eov, eil, emul, ep);
        @(negedge clk);
        alu_op = op; funct = fn; shamt = sh; op_a = a; op_b = b;
        in_valid = 1'b1; out_ready = 1'b1;
        waitc = 0;
        while (!in_ready && waitc < 100) begin
            @(negedge clk);
            waitc++;
        end
        if (!in_ready) chk({tag, "_accept_timeout"}, in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        rdy_low = 1'b1;
        while (!out_valid && lat < 100) begin
            rdy_low = rdy_low & !in_ready;
            @(negedge clk);
            lat++;
        end
        chk({tag, "_latency"}, lat, emul ? 32 : 0);
        if (emul) begin
            chk({tag, "_mul_stall"}, rdy_low, 1);
            hi_m = ep[63:32];
            lo_m = ep[31:0];
        end
        chk({tag, "_result"}, result, er);
        chk({tag, "_zero"}, zero, (er == 0));
        chk({tag, "_ovf"}, ovf, eov);
        chk({tag, "_illegal"}, illegal, eil);
        last_res = result; last_zero = zero; last_ovf = ovf; last_ill = illegal;
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'h7FFFFFFF;
            default: return $urandom();
        endcase
    endfunction

    initial begin
        logic [31:0] ra, rb, rc;
        logic        dov, dil, dmul;
        logic [63:0] dp;
        logic        quiet;

        // Reset state
        #2;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_result", result, 0);
        chk("reset_flags", {zero, ovf, illegal}, 0);
        chk("reset_in_ready", in_ready, 1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases
        run_op("add_ovf", 3'b010, 6'b100000, 5'd0, 32'h7FFFFFFF, 32'h1);
        chk("spec_add_res", last_res, 32'h80000000);
        chk("spec_add_ovf", last_ovf, 1);
        run_op("addu", 3'b010, 6'b100001, 5'd0, 32'h7FFFFFFF, 32'h1);
        chk("spec_addu_flags", {last_ovf, last_zero}, 0);
        run_op("sra", 3'b010, 6'b000011, 5'd4, 32'h0, 32'h80000000);
        chk("spec_sra", last_res, 32'hF8000000);
        run_op("srlv", 3'b010, 6'b000110, 5'd0, 32'h24, 32'h80000000);
        chk("spec_srlv", last_res, 32'h08000000);
        run_op("sub_zero", 3'b001, 6'b0, 5'd0, 32'd5, 32'd5);
        chk("spec_sub_zero", last_zero, 1);
        run_op("lui", 3'b111, 6'b0, 5'd0, 32'h0, 32'h0000ABCD);
        chk("spec_lui", last_res, 32'hABCD0000);
        run_op("mult", 3'b010, 6'b011000, 5'd0, 32'hFFFFFFFD, 32'd5);
        chk("spec_mult_lo", last_res, 32'hFFFFFFF1);
        run_op("mfhi", 3'b010, 6'b010000, 5'd0, 32'h0, 32'h0);
        chk("spec_mfhi", last_res, 32'hFFFFFFFF);
        run_op("multu", 3'b010, 6'b011001, 5'd0, 32'hFFFFFFFF, 32'd2);
        chk("spec_multu_lo", last_res, 32'hFFFFFFFE);
        run_op("mflo", 3'b010, 6'b010010, 5'd0, 32'h0, 32'h0);
        chk("spec_mflo", last_res, 32'hFFFFFFFE);
        run_op("mfhi2", 3'b010, 6'b010000, 5'd0, 32'h0, 32'h0);
        chk("spec_multu_hi", last_res, 32'h00000001);
        run_op("illegal", 3'b010, 6'b111111, 5'd0, 32'h1234, 32'h5678);
        chk("spec_illegal", {last_ill, last_res}, {1'b1, 32'h0});
        run_op("ill_hi", 3'b010, 6'b010000, 5'd0, 32'h0, 32'h0);
        run_op("ill_lo", 3'b010, 6'b010010, 5'd0, 32'h0, 32'h0);

        // Backpressure: hold result under out_ready=0, then stream one per cycle
        @(negedge clk);
        ra = 32'hF0F0_1234 | 32'h0000_8001;
        rb = 32'h0000_0003 ^ 32'h1111_0000;
        rc = 32'h0000_00FF & 32'hAAAA_AAAA;
        alu_op = 3'b100; op_a = 32'hF0F0_1234; op_b = 32'h0000_8001; in_valid = 1'b1; out_ready = 1'b0;
        chk("bp_ready_first", in_ready, 1);
        @(negedge clk);
        alu_op = 3'b010; funct = 6'b100110; op_a = 32'h0000_0003; op_b = 32'h1111_0000;
        for (int i = 0; i < 3; i++) begin
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_ready", in_ready, 0);
            chk("bp_hold_result", result, ra);
            @(negedge clk);
        end
        chk("bp_hold_result_end", result, ra);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        @(negedge clk);
        chk("bp_stream_b", {out_valid, result}, {1'b1, rb});
        alu_op = 3'b011; op_a = 32'h0000_00FF; op_b = 32'hAAAA_AAAA;
        @(negedge clk);
        chk("bp_stream_c", {out_valid, result}, {1'b1, rc});
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_drained", out_valid, 0);

        // Randomized operations
        for (int i = 0; i < 120; i++) begin
            logic [2:0] rop;
            logic [5:0] rfn;
            rop = ($urandom_range(0, 1) == 0) ? 3'b010 : 3'($urandom_range(0, 7));
            rfn = ($urandom_range(0, 9) == 0) ? 6'($urandom()) : legal_fn[$urandom_range(0, 19)];
            run_op("rand", rop, rfn, 5'($urandom()), pick(), pick());
        end

        // Reset in the middle of a multiply
        @(negedge clk);
        alu_op = 3'b010; funct = 6'b011000; op_a = 32'h0001_2345; op_b = 32'hFFFF_0007;
        in_valid = 1'b1; out_ready = 1'b1;
        chk("rst_mul_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_mul_busy", in_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_mul_out_valid", out_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        hi_m = '0;
        lo_m = '0;
        chk("rst_mul_ready_after", in_ready, 1);
        quiet = 1'b1;
        repeat (40) begin
            @(negedge clk);
            quiet = quiet & !out_valid;
        end
        chk("rst_mul_no_pulse", quiet, 1);
        run_op("rst_hi", 3'b010, 6'b010000, 5'd0, 32'h0, 32'h0);
        run_op("rst_lo", 3'b010, 6'b010010, 5'd0, 32'h0, 32'h0);
        model(3'b010, 6'b010010, 5'd0, 32'h0, 32'h0, hi_m, lo_m, ra, dov, dil, dmul, dp);
        chk("rst_lo_value", last_res, ra);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
